cache_control: RTL and testbench
================================

CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports listed in this order:
  - clk  in  1  clock.
  - rst  in  1  synchronous active-high reset.
REQ-002 CPU-side ports SHALL be:
  - mem_read  in  1  CPU read request, held until mem_resp.
  - mem_write  in  1  CPU write request, held until mem_resp.
  - mem_resp  out  1  one-cycle completion pulse.
REQ-003 Tag/status ports SHALL be:
  - hit0, hit1  in  1 each  tag match AND valid, per way.
  - dirty0, dirty1  in  1 each  stored dirty bit, per way.
  - valid0, valid1  in  1 each  stored valid bit, per way.
  - lru  in  1  0 means way0 is victim, 1 means way1 is victim.
REQ-004 Physical-memory ports SHALL be:
  - pmem_read  out  1  line fetch request, held until pmem_resp.
  - pmem_write  out  1  line writeback request, held until pmem_resp.
  - pmem_resp  in  1  one-cycle completion from memory.
REQ-005 Array-control outputs SHALL be:
  - way_sel  out  waymux::waymux_sel_t  target way.
  - data_ld  out  1  data array write enable.
  - data_src  out  datamux::datamux_sel_t  cache means full-line fill; cpu means byte-masked CPU write.
  - tag_ld, valid_ld, dirty_ld, lru_ld  out  1 each  per-array load enables.
  - dirty_in, lru_in  out  1 each  values to load.
  - addr_sel  out  1  0 selects the CPU tag for the pmem address; 1 selects the victim's stored tag.
REQ-006 Statistics outputs SHALL be hit_count, miss_count and wb_count, each out, 32 bits, wrapping counters.

Function
REQ-007 The FSM SHALL have exactly three states: IDLE, WRITEBACK, FETCH.
REQ-008 All outputs not explicitly driven in a state SHALL default to 0, with way_sel=way0 and data_src=cpu.
REQ-009 In IDLE, a request (mem_read|mem_write) with hit0|hit1 set SHALL complete in the same cycle:
  - mem_resp=1.
  - way_sel = hitting way.
  - lru_ld=1, with lru_in = 1 for way0 and 0 for way1.
REQ-010 A write hit SHALL additionally drive data_ld=1, data_src=cpu, dirty_ld=1 and dirty_in=1.
REQ-011 If hit0 and hit1 are both set, way0 SHALL take priority (an illegal input, but deterministic).
REQ-012 If mem_read and mem_write are both set, the request SHALL be treated as a write.
REQ-013 On an IDLE miss, the victim SHALL be way lru.
  - Victim valid and dirty: go to WRITEBACK.
  - Otherwise: go to FETCH.
  - miss_count increments once per miss, in that cycle.
REQ-014 In WRITEBACK the block SHALL drive pmem_write=1, addr_sel=1 and way_sel=victim; on pmem_resp it SHALL go to FETCH and increment wb_count.
REQ-015 In FETCH the block SHALL drive pmem_read=1, addr_sel=0 and way_sel=victim.
REQ-016 In the FETCH cycle where pmem_resp arrives, the block SHALL drive:
  - data_ld=1 with data_src=cache.
  - tag_ld=1.
  - valid_ld=1.
  - dirty_ld=1 with dirty_in=0.
  - next state IDLE.
REQ-017 After a fill, the block SHALL return to IDLE, where the still-held request hits; miss latency is therefore the memory cycles plus 1, and mem_resp is never asserted from WRITEBACK or FETCH.
REQ-018 The victim way SHALL be registered on miss entry, so that lru changing during WRITEBACK or FETCH does not change the victim.
REQ-019 pmem_resp seen in IDLE SHALL be ignored.
REQ-020 If the request is withdrawn mid-miss, the fill SHALL still complete and the block SHALL return to IDLE without mem_resp.
REQ-021 hit_count SHALL increment on every IDLE hit cycle, including the completing hit after a fill.
REQ-022 All counters SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-023 While rst is high at a clock edge, the state SHALL become IDLE, the victim register way0, and all counters 0.
REQ-024 A reset asserted during WRITEBACK or FETCH SHALL deassert pmem_read/pmem_write from the next cycle, with no array loads issued.
REQ-025 Combinational outputs in the reset cycle SHALL follow the IDLE decode; the bench SHALL hold mem_read=mem_write=0 during reset.

Structure
REQ-026 The enums waymux_sel_t {way0, way1} and datamux_sel_t {cache, cpu} SHALL be declared in the shared packages waymux and datamux; the state enum SHALL be local to the module.
REQ-027 The three counters SHALL be instances of one sub-module, stat_counter (32-bit, synchronous clear, increment enable).
REQ-028 Next-state logic and output decode SHALL each be a single always_comb block; state, victim and counters SHALL be updated in always_ff.

Verification
REQ-029 Read hit way1: mem_read=1, hit1=1 in IDLE -> same-cycle mem_resp=1, way_sel=way1, lru_ld=1, lru_in=0, hit_count=1.
REQ-030 Write hit way0: mem_write=1, hit0=1 -> data_ld=1, data_src=cpu, dirty_ld=1, dirty_in=1, mem_resp=1.
REQ-031 Clean miss, lru=1, pmem_resp after 3 cycles -> FETCH with pmem_read high 3 cycles, fill cycle data_src=cache, way_sel=way1, dirty_in=0, then hit mem_resp; miss_count=1, wb_count=0.
REQ-032 Dirty miss, lru=0, valid0=dirty0=1 -> WRITEBACK with pmem_write=1, addr_sel=1, then FETCH with addr_sel=0; wb_count=1; lru toggled mid-miss leaves way_sel=way0.
REQ-033 rst asserted in the second FETCH cycle -> next cycle IDLE, pmem_read=0, counters 0, no data_ld.
REQ-034 Counter preset to 0xFFFFFFFF plus one hit -> hit_count=0.

Source files
------------

// File: rtl/cache_control_pkg.sv
// rtl/cache_control_pkg.sv - shared way-mux and data-mux select encodings
package waymux;
  typedef enum logic {
    way0 = 1'b0,
    way1 = 1'b1
  } waymux_sel_t;
endpackage

package datamux;
  typedef enum logic {
    cache = 1'b0,
    cpu   = 1'b1
  } datamux_sel_t;
endpackage

// File: rtl/cache_control_stat_counter.sv
// rtl/cache_control_stat_counter.sv - 32-bit wrapping event counter with synchronous clear
module stat_counter (
  input  logic        clk,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] count
);

  // Clear wins over increment; natural overflow gives the wrap to zero.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/cache_control.sv
// rtl/cache_control.sv - two-way cache controller FSM with hit/miss/writeback statistics
module cache_control
  import waymux::*;
  import datamux::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  output logic         mem_resp,
  input  logic         hit0,
  input  logic         hit1,
  input  logic         dirty0,
  input  logic         dirty1,
  input  logic         valid0,
  input  logic         valid1,
  input  logic         lru,
  output logic         pmem_read,
  output logic         pmem_write,
  input  logic         pmem_resp,
  output waymux_sel_t  way_sel,
  output logic         data_ld,
  output datamux_sel_t data_src,
  output logic         tag_ld,
  output logic         valid_ld,
  output logic         dirty_ld,
  output logic         lru_ld,
  output logic         dirty_in,
  output logic         lru_in,
  output logic         addr_sel,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count,
  output logic [31:0]  wb_count
);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH
  } state_t;

  state_t      state;
  state_t      state_next;
  state_t      dec_state;
  waymux_sel_t victim;

  logic req;
  logic any_hit;
  logic victim_wb;
  logic hit_inc;
  logic miss_inc;
  logic wb_inc;

  assign req       = mem_read | mem_write;
  assign any_hit   = hit0 | hit1;
  // The way about to be evicted is the current lru way; only a valid dirty line needs writing back.
  assign victim_wb = lru ? (valid1 & dirty1) : (valid0 & dirty0);
  // During reset the outputs decode as IDLE so no memory request or array load escapes.
  assign dec_state = rst ? IDLE : state;

  // State register and victim capture on miss entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      victim <= way0;
    end else begin
      state <= state_next;
      if (miss_inc) begin
        victim <= waymux_sel_t'(lru);
      end
    end
  end

  // Next-state selection.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (req && !any_hit) begin
          state_next = victim_wb ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        if (pmem_resp) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (pmem_resp) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode; everything idles at zero with way0 and CPU data selected.
  always_comb begin
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    way_sel    = way0;
    data_ld    = 1'b0;
    data_src   = cpu;
    tag_ld     = 1'b0;
    valid_ld   = 1'b0;
    dirty_ld   = 1'b0;
    lru_ld     = 1'b0;
    dirty_in   = 1'b0;
    lru_in     = 1'b0;
    addr_sel   = 1'b0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    wb_inc     = 1'b0;
    unique case (dec_state)
      IDLE: begin
        if (req) begin
          if (any_hit) begin
            // way0 wins when both ways claim a hit; lru points at the other way.
            mem_resp = 1'b1;
            way_sel  = hit0 ? way0 : way1;
            lru_ld   = 1'b1;
            lru_in   = hit0;
            hit_inc  = 1'b1;
            if (mem_write) begin
              data_ld  = 1'b1;
              data_src = cpu;
              dirty_ld = 1'b1;
              dirty_in = 1'b1;
            end
          end else begin
            miss_inc = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        addr_sel   = 1'b1;
        way_sel    = victim;
        wb_inc     = pmem_resp;
      end
      FETCH: begin
        pmem_read = 1'b1;
        way_sel   = victim;
        if (pmem_resp) begin
          data_ld  = 1'b1;
          data_src = cache;
          tag_ld   = 1'b1;
          valid_ld = 1'b1;
          dirty_ld = 1'b1;
          dirty_in = 1'b0;
        end
      end
      default: ;
    endcase
  end

  stat_counter u_hit_ctr (
    .clk   (clk),
    .clr   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  stat_counter u_miss_ctr (
    .clk   (clk),
    .clr   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

  stat_counter u_wb_ctr (
    .clk   (clk),
    .clr   (rst),
    .inc   (wb_inc),
    .count (wb_count)
  );

endmodule

// File: tb/tb_cache_control.sv
// tb/tb_cache_control.sv - self-checking bench for cache_control
module tb_cache_control;
  import waymux::*;
  import datamux::*;

  logic         clk;
  logic         rst;
  logic         mem_read;
  logic         mem_write;
  logic         mem_resp;
  logic         hit0;
  logic         hit1;
  logic         dirty0;
  logic         dirty1;
  logic         valid0;
  logic         valid1;
  logic         lru;
  logic         pmem_read;
  logic         pmem_write;
  logic         pmem_resp;
  waymux_sel_t  way_sel;
  logic         data_ld;
  datamux_sel_t data_src;
  logic         tag_ld;
  logic         valid_ld;
  logic         dirty_ld;
  logic         lru_ld;
  logic         dirty_in;
  logic         lru_in;
  logic         addr_sel;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
  logic [31:0]  wb_count;

  int checks;
  int failures;
  logic [31:0] exp_hit;
  logic [31:0] exp_miss;
  logic [31:0] exp_wb;

  cache_control dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_resp   (mem_resp),
    .hit0       (hit0),
    .hit1       (hit1),
    .dirty0     (dirty0),
    .dirty1     (dirty1),
    .valid0     (valid0),
    .valid1     (valid1),
    .lru        (lru),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_resp  (pmem_resp),
    .way_sel    (way_sel),
    .data_ld    (data_ld),
    .data_src   (data_src),
    .tag_ld     (tag_ld),
    .valid_ld   (valid_ld),
    .dirty_ld   (dirty_ld),
    .lru_ld     (lru_ld),
    .dirty_in   (dirty_in),
    .lru_in     (lru_in),
    .addr_sel   (addr_sel),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .wb_count   (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_idle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    hit0      = 1'b0;
    hit1      = 1'b0;
    dirty0    = 1'b0;
    dirty1    = 1'b0;
    valid0    = 1'b0;
    valid1    = 1'b0;
    lru       = 1'b0;
    pmem_resp = 1'b0;
  endtask

  // Idle cycle after each transaction: stray pmem_resp must be ignored, counters must match the model.
  task automatic check_gap(input string tag);
    @(negedge clk);
    set_idle();
    pmem_resp = 1'($urandom_range(0, 1));
    #1;
    checks++;
    if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0 || data_ld !== 1'b0 ||
        tag_ld !== 1'b0 || lru_ld !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_gap mem_resp=%b pmem_rd=%b pmem_wr=%b data_ld=%b tag_ld=%b lru_ld=%b required all 0",
               tag, mem_resp, pmem_read, pmem_write, data_ld, tag_ld, lru_ld);
    end
    checks++;
    if (hit_count !== exp_hit || miss_count !== exp_miss || wb_count !== exp_wb) begin
      failures++;
      $display("FAIL %s_counters got hit=%0h miss=%0h wb=%0h required hit=%0h miss=%0h wb=%0h",
               tag, hit_count, miss_count, wb_count, exp_hit, exp_miss, exp_wb);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_hit  = '0;
    exp_miss = '0;
    exp_wb   = '0;
    checks++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0 || wb_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_counters got hit=%0h miss=%0h wb=%0h required 0 0 0", hit_count, miss_count, wb_count);
    end
    checks++;
    if ({mem_resp, pmem_read, pmem_write, data_ld, tag_ld, valid_ld, dirty_ld, lru_ld, addr_sel} !== 9'b0 ||
        way_sel !== way0 || data_src !== cpu) begin
      failures++;
      $display("FAIL reset_outputs got resp=%b prd=%b pwr=%b dld=%b way=%b src=%b required 0 0 0 0 0 1",
               mem_resp, pmem_read, pmem_write, data_ld, way_sel, data_src);
    end
  endtask

  // A hit completes in one cycle on the lowest hitting way; writes also mark the line dirty.
  task automatic test_hit(input bit rd, input bit wr, input bit h0, input bit h1);
    bit hw;
    hw = !h0;
    @(negedge clk);
    set_idle();
    mem_read  = rd;
    mem_write = wr;
    hit0      = h0;
    hit1      = h1;
    lru       = 1'($urandom_range(0, 1));
    valid0    = 1'($urandom_range(0, 1));
    dirty0    = 1'($urandom_range(0, 1));
    #1;
    checks++;
    if (mem_resp !== 1'b1 || way_sel !== hw || lru_ld !== 1'b1 || lru_in !== !hw) begin
      failures++;
      $display("FAIL hit_resp rd=%b wr=%b h0=%b h1=%b got resp=%b way=%b lru_ld=%b lru_in=%b required 1 %b 1 %b",
               rd, wr, h0, h1, mem_resp, way_sel, lru_ld, lru_in, hw, !hw);
    end
    checks++;
    if (data_ld !== wr || dirty_ld !== wr || dirty_in !== wr || data_src !== cpu || tag_ld !== 1'b0 ||
        valid_ld !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      failures++;
      $display("FAIL hit_loads wr=%b got data_ld=%b dirty_ld=%b dirty_in=%b src=%b tag_ld=%b prd=%b pwr=%b required %b %b %b 1 0 0 0",
               wr, data_ld, dirty_ld, dirty_in, data_src, tag_ld, pmem_read, pmem_write, wr, wr, wr);
    end
    exp_hit++;
    check_gap("hit");
  endtask

  // Miss: optional writeback of the victim, a fill, then the held request hits the filled way.
  task automatic test_miss(input bit rd, input bit wr, input bit l, input bit v0, input bit d0,
                           input bit v1, input bit d1, input int wlat, input int flat,
                           input bit toggle, input bit withdraw);
    bit vic;
    bit need_wb;
    bit last;
    vic     = l;
    need_wb = l ? (v1 && d1) : (v0 && d0);
    @(negedge clk);
    set_idle();
    mem_read  = rd || !wr;
    mem_write = wr;
    lru       = l;
    valid0    = v0;
    dirty0    = d0;
    valid1    = v1;
    dirty1    = d1;
    #1;
    checks++;
    if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0 || data_ld !== 1'b0 || lru_ld !== 1'b0) begin
      failures++;
      $display("FAIL miss_entry got resp=%b prd=%b pwr=%b dld=%b lru_ld=%b required all 0",
               mem_resp, pmem_read, pmem_write, data_ld, lru_ld);
    end
    exp_miss++;
    if (need_wb) begin
      for (int k = 1; k <= wlat; k++) begin
        @(negedge clk);
        pmem_resp = (k == wlat);
        if (toggle) lru = ~lru;
        if (withdraw) begin
          mem_read  = 1'b0;
          mem_write = 1'b0;
        end
        #1;
        checks++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || addr_sel !== 1'b1 || way_sel !== vic ||
            mem_resp !== 1'b0 || data_ld !== 1'b0 || tag_ld !== 1'b0 || lru_ld !== 1'b0) begin
          failures++;
          $display("FAIL wb_cycle%0d got pwr=%b prd=%b addr_sel=%b way=%b resp=%b dld=%b required 1 0 1 %b 0 0",
                   k, pmem_write, pmem_read, addr_sel, way_sel, mem_resp, data_ld, vic);
        end
      end
      exp_wb++;
    end
    for (int k = 1; k <= flat; k++) begin
      @(negedge clk);
      last      = (k == flat);
      pmem_resp = last;
      if (toggle) lru = ~lru;
      if (withdraw) begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      #1;
      checks++;
      if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || addr_sel !== 1'b0 || way_sel !== vic || mem_resp !== 1'b0 ||
          data_ld !== last || data_src !== (last ? cache : cpu) || tag_ld !== last || valid_ld !== last ||
          dirty_ld !== last || dirty_in !== 1'b0 || lru_ld !== 1'b0) begin
        failures++;
        $display("FAIL fetch_cycle%0d got prd=%b pwr=%b addr_sel=%b way=%b resp=%b dld=%b src=%b tag=%b val=%b dld2=%b din=%b required 1 0 0 %b 0 %b %b %b %b %b 0",
                 k, pmem_read, pmem_write, addr_sel, way_sel, mem_resp, data_ld, data_src, tag_ld, valid_ld,
                 dirty_ld, dirty_in, vic, last, !last, last, last, last);
      end
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    hit0      = !vic;
    hit1      = vic;
    #1;
    checks++;
    if (withdraw) begin
      if (mem_resp !== 1'b0 || data_ld !== 1'b0 || lru_ld !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
        failures++;
        $display("FAIL withdrawn_return got resp=%b dld=%b lru_ld=%b prd=%b pwr=%b required all 0",
                 mem_resp, data_ld, lru_ld, pmem_read, pmem_write);
      end
    end else begin
      if (mem_resp !== 1'b1 || way_sel !== vic || lru_ld !== 1'b1 || lru_in !== !vic || data_ld !== wr ||
          dirty_ld !== wr || dirty_in !== wr || pmem_read !== 1'b0) begin
        failures++;
        $display("FAIL miss_completion got resp=%b way=%b lru_ld=%b lru_in=%b dld=%b dirty_ld=%b prd=%b required 1 %b 1 %b %b %b 0",
                 mem_resp, way_sel, lru_ld, lru_in, data_ld, dirty_ld, pmem_read, vic, !vic, wr, wr);
      end
      exp_hit++;
    end
    check_gap("miss");
  endtask

  task automatic test_read_hit_way1();
    test_hit(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_write_hit_way0();
    test_hit(1'b0, 1'b1, 1'b1, 1'b0);
    test_hit(1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_clean_miss();
    test_miss(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2, 3, 1'b0, 1'b0);
  endtask

  task automatic test_dirty_miss();
    test_miss(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 2, 1'b1, 1'b0);
  endtask

  task automatic test_withdraw();
    test_miss(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 2, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge clk);
    set_idle();
    mem_read = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (pmem_read !== 1'b1) begin
      failures++;
      $display("FAIL rstfetch_first_fetch got prd=%b required 1", pmem_read);
    end
    @(negedge clk);
    mem_read = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    pmem_resp = 1'b1;
    #1;
    exp_hit  = '0;
    exp_miss = '0;
    exp_wb   = '0;
    checks++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || data_ld !== 1'b0 || tag_ld !== 1'b0 ||
        valid_ld !== 1'b0 || dirty_ld !== 1'b0) begin
      failures++;
      $display("FAIL rstfetch_outputs got prd=%b pwr=%b dld=%b tag=%b val=%b dirty_ld=%b required all 0",
               pmem_read, pmem_write, data_ld, tag_ld, valid_ld, dirty_ld);
    end
    checks++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0 || wb_count !== 32'd0) begin
      failures++;
      $display("FAIL rstfetch_counters got hit=%0h miss=%0h wb=%0h required 0 0 0", hit_count, miss_count, wb_count);
    end
    pmem_resp = 1'b0;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    set_idle();
    force dut.u_hit_ctr.count = 32'hFFFF_FFFF;
    #1;
    release dut.u_hit_ctr.count;
    exp_hit = 32'hFFFF_FFFF;
    test_hit(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (hit_count !== 32'd0) begin
      failures++;
      $display("FAIL wrap_hit_count got %0h required 0", hit_count);
    end
  endtask

  task automatic test_random();
    bit rd;
    bit wr;
    int r;
    for (int n = 0; n < 40; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(1, 3);
        test_hit(rd, wr, r[0], r[1]);
      end else begin
        test_miss(rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 4),
                  $urandom_range(1, 4), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_hit  = '0;
    exp_miss = '0;
    exp_wb   = '0;
    rst      = 1'b1;
    set_idle();
    test_reset();
    test_read_hit_way1();
    test_write_hit_way0();
    test_clean_miss();
    test_dirty_miss();
    test_withdraw();
    test_random();
    test_reset_mid_fetch();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
